// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage ALU. Single-cycle ops complete with a one-cycle
// DONE pulse; multiply is an iterative shift-add that holds BUSY for WIDTH cycles.
module alu_exec_unit #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [3:0]       ALU_CONTROL,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             OVERFLOW,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000;
    localparam logic [3:0] OP_INV = 4'b1001;

    // The counter is one bit wider than SHW so it can hold WIDTH itself.
    localparam logic [SHW:0] LAST_STEP = (SHW + 1)'(WIDTH - 1);
    localparam logic [SHW:0] CNT_ONE   = (SHW + 1)'(1);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             overflow_q;
    logic             done_q;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SHW:0]     count;

    logic [WIDTH-1:0] acc_next;
    logic             last_step;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic             slt_bit;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;
    logic             start_mul;

    assign sum       = A + B;
    assign diff      = A - B;
    assign shamt     = B[SHW-1:0];
    assign slt_bit   = ($signed(A) < $signed(B));
    assign start_mul = START && (ALU_CONTROL == OP_MUL);
    assign acc_next  = acc + (mplier[0] ? mcand : '0);
    assign last_step = (count == LAST_STEP);

    // Single-cycle result and signed-overflow for the captured opcode.
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (ALU_CONTROL)
            OP_ADD: begin
                alu_result   = sum;
                alu_overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result   = diff;
                alu_overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLL:  alu_result = A << shamt;
            OP_SRL:  alu_result = A >> shamt;
            OP_AND:  alu_result = A & B;
            OP_OR:   alu_result = A | B;
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_XOR:  alu_result = A ^ B;
            OP_INV:  alu_result = ~A;
            default: alu_result = '0;
        endcase
    end

    // State register; reset wins over any request at the same edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: enter MUL on a multiply request, leave on the last step.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_mul) state_next = MUL;
            MUL:     if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add iteration and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            result_q   <= '0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            count      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mul) begin
                        mcand  <= A;
                        mplier <= B;
                        acc    <= '0;
                        count  <= '0;
                    end else if (START) begin
                        result_q   <= alu_result;
                        zero_q     <= (alu_result == '0);
                        overflow_q <= alu_overflow;
                        done_q     <= 1'b1;
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_ONE;
                    if (last_step) begin
                        result_q   <= acc_next;
                        zero_q     <= (acc_next == '0);
                        overflow_q <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RESULT   = result_q;
    assign ZERO     = zero_q;
    assign OVERFLOW = overflow_q;
    assign DONE     = done_q;
    assign BUSY     = (state == MUL);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit (WIDTH=16).
module tb_alu_exec_unit;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [3:0]  ALU_CONTROL;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] RESULT;
    logic        ZERO;
    logic        OVERFLOW;
    logic        BUSY;
    logic        DONE;

    int errors = 0;
    int checks = 0;

    alu_exec_unit #(.WIDTH(16)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .ALU_CONTROL (ALU_CONTROL),
        .A           (A),
        .B           (B),
        .RESULT      (RESULT),
        .ZERO        (ZERO),
        .OVERFLOW    (OVERFLOW),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Present one request for exactly one rising edge; returns at the next falling edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        ALU_CONTROL = op;
        A = a;
        B = b;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        issue(4'b0000, 16'h0001, 16'h0001);
        @(negedge CLK);
        checks++;
        if (RESULT !== 16'h0000 || ZERO !== 1'b1 || OVERFLOW !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got R=%h Z=%b O=%b BUSY=%b DONE=%b expected R=0000 Z=1 O=0 BUSY=0 DONE=0",
                     RESULT, ZERO, OVERFLOW, BUSY, DONE);
        end
        RESET = 1'b0;
    endtask

    task automatic test_add_sub();
        issue(4'b0000, 16'h7FFF, 16'h0001);
        checks++;
        if (RESULT !== 16'h8000 || OVERFLOW !== 1'b1 || ZERO !== 1'b0 || DONE !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_ovf: got R=%h O=%b Z=%b D=%b expected R=8000 O=1 Z=0 D=1", RESULT, OVERFLOW, ZERO, DONE);
        end
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_done_single: got DONE=%b expected 0", DONE);
        end
        issue(4'b0001, 16'h0005, 16'h0005);
        checks++;
        if (RESULT !== 16'h0000 || ZERO !== 1'b1 || OVERFLOW !== 1'b0 || DONE !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sub_zero: got R=%h Z=%b O=%b D=%b expected R=0000 Z=1 O=0 D=1", RESULT, ZERO, OVERFLOW, DONE);
        end
        issue(4'b0001, 16'h8000, 16'h0001);
        checks++;
        if (RESULT !== 16'h7FFF || OVERFLOW !== 1'b1 || ZERO !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sub_ovf: got R=%h O=%b Z=%b expected R=7FFF O=1 Z=0", RESULT, OVERFLOW, ZERO);
        end
    endtask

    task automatic test_mult();
        int busy_cycles;
        issue(4'b0010, 16'h0123, 16'h0045);
        busy_cycles = 0;
        while (BUSY === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            if (DONE !== 1'b0) begin
                checks++;
                errors++;
                $display("[TB] FAIL mult_busy_done_overlap: got DONE=%b expected 0 while BUSY", DONE);
            end
            ALU_CONTROL = 4'b0000;
            A = 16'h1111;
            B = 16'h2222;
            START = (busy_cycles % 2) == 1;
            @(negedge CLK);
        end
        START = 1'b0;
        checks++;
        if (busy_cycles !== 16) begin
            errors++;
            $display("[TB] FAIL mult_busy_len: got %0d cycles expected 16", busy_cycles);
        end
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || RESULT !== 16'h4E6F || OVERFLOW !== 1'b0 || ZERO !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mult_result: got D=%b BUSY=%b R=%h O=%b Z=%b expected D=1 BUSY=0 R=4E6F O=0 Z=0",
                     DONE, BUSY, RESULT, OVERFLOW, ZERO);
        end
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || RESULT !== 16'h4E6F) begin
            errors++;
            $display("[TB] FAIL mult_after: got D=%b BUSY=%b R=%h expected D=0 BUSY=0 R=4E6F", DONE, BUSY, RESULT);
        end

        issue(4'b0010, 16'hFFFF, 16'hFFFF);
        busy_cycles = 0;
        while (BUSY === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            @(negedge CLK);
        end
        checks++;
        if (busy_cycles !== 16 || DONE !== 1'b1 || RESULT !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL mult_ffff: got cycles=%0d D=%b R=%h expected cycles=16 D=1 R=0001", busy_cycles, DONE, RESULT);
        end
    endtask

    task automatic test_shift_compare();
        logic [3:0]  ops  [6] = '{4'b0011, 4'b0100, 4'b0111, 4'b0111, 4'b1001, 4'b1100};
        logic [15:0] avec [6] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0001, 16'h00F0, 16'h1234};
        logic [15:0] bvec [6] = '{16'h0013, 16'h000F, 16'h0001, 16'hFFFF, 16'hABCD, 16'h5678};
        logic [15:0] expv [6] = '{16'h0008, 16'h0001, 16'h0001, 16'h0000, 16'hFF0F, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], avec[i], bvec[i]);
            checks++;
            if (RESULT !== expv[i] || DONE !== 1'b1 || OVERFLOW !== 1'b0 || ZERO !== (expv[i] == 16'h0000)) begin
                errors++;
                $display("[TB] FAIL shift_cmp[%0d] op=%b: got R=%h D=%b O=%b Z=%b expected R=%h D=1 O=0",
                         i, ops[i], RESULT, DONE, OVERFLOW, ZERO, expv[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        issue(4'b0010, 16'h0003, 16'h0004);
        repeat (4) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_busy5: got BUSY=%b expected 1", BUSY);
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 16'h0000 || ZERO !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_state: got BUSY=%b D=%b R=%h Z=%b expected BUSY=0 D=0 R=0000 Z=1", BUSY, DONE, RESULT, ZERO);
        end
        issue(4'b0000, 16'h0002, 16'h0002);
        checks++;
        if (RESULT !== 16'h0004 || DONE !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_then_add: got R=%h D=%b expected R=0004 D=1", RESULT, DONE);
        end
        repeat (14) begin
            @(negedge CLK);
            if (DONE !== 1'b0) begin
                checks++;
                errors++;
                $display("[TB] FAIL abort_ghost_done: got DONE=%b expected 0", DONE);
            end
        end
    endtask

    task automatic test_back_to_back();
        int busy_cycles;
        A = 16'h0F0F;
        B = 16'h00FF;
        START = 1'b1;
        ALU_CONTROL = 4'b0101;
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b1 || RESULT !== 16'h000F) begin
            errors++;
            $display("[TB] FAIL b2b_and: got D=%b R=%h expected D=1 R=000F", DONE, RESULT);
        end
        ALU_CONTROL = 4'b0110;
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b1 || RESULT !== 16'h0FFF) begin
            errors++;
            $display("[TB] FAIL b2b_or: got D=%b R=%h expected D=1 R=0FFF", DONE, RESULT);
        end
        ALU_CONTROL = 4'b1000;
        @(negedge CLK);
        START = 1'b0;
        checks++;
        if (DONE !== 1'b1 || RESULT !== 16'h0FF0) begin
            errors++;
            $display("[TB] FAIL b2b_xor: got D=%b R=%h expected D=1 R=0FF0", DONE, RESULT);
        end

        issue(4'b0010, 16'h0002, 16'h0003);
        busy_cycles = 0;
        while (BUSY === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            @(negedge CLK);
        end
        checks++;
        if (DONE !== 1'b1 || RESULT !== 16'h0006) begin
            errors++;
            $display("[TB] FAIL b2b_mult: got D=%b R=%h expected D=1 R=0006", DONE, RESULT);
        end
        issue(4'b0000, 16'h0005, 16'h0006);
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || RESULT !== 16'h000B) begin
            errors++;
            $display("[TB] FAIL b2b_mult_add: got D=%b BUSY=%b R=%h expected D=1 BUSY=0 R=000B", DONE, BUSY, RESULT);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        RESET = 1'b1;
        START = 1'b0;
        ALU_CONTROL = 4'b0000;
        A = 16'h0000;
        B = 16'h0000;
        @(negedge CLK);
        test_reset();
        test_add_sub();
        test_mult();
        test_shift_compare();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
